// File: rtl/picobello_pkg.sv
// Shared types and helpers for the picobello cluster power sequencer.
package picobello_pkg;

   // Requested direction of a power sequence.
   typedef enum logic {
      POWER_UP   = 1'b0,
      POWER_DOWN = 1'b1
   } pb_pwr_op_e;

   // Largest of three values; sizes the shared settle/hold/timeout counter.
   function automatic int unsigned pb_max3(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) begin
         m = b;
      end else begin
         m = m;
      end
      if (c > m) begin
         m = c;
      end else begin
         m = m;
      end
      return m;
   endfunction

endpackage

// File: rtl/pb_cluster_pwr_seq_lzc.sv
// Lowest-set-bit finder (trailing-zero count) used to pick the next cluster.
module pb_cluster_pwr_seq_lzc #(
   parameter int unsigned  Width = 16,
   localparam int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
   input  logic [Width-1:0] in_i,
   output logic [IdxW-1:0]  cnt_o,
   output logic             empty_o
);

   // Scan upwards and keep the first set bit found.
   always_comb begin
      cnt_o   = '0;
      empty_o = 1'b1;
      for (int i = 0; i < int'(Width); i++) begin
         if (in_i[i] && empty_o) begin
            cnt_o   = IdxW'(i);
            empty_o = 1'b0;
         end else begin
            cnt_o   = cnt_o;
         end
      end
   end

endmodule

// File: rtl/pb_cluster_pwr_seq.sv
// Cluster power sequencer: staggers clock enable, reset release and NoC
// isolation of the cluster tiles one cluster at a time.
module pb_cluster_pwr_seq
   import picobello_pkg::*;
#(
   parameter int unsigned NumClusters     = 16,
   parameter int unsigned ClkSettleCycles = 8,
   parameter int unsigned RstHoldCycles   = 16,
   parameter int unsigned AckTimeout      = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_valid_i,
   output logic                   req_ready_o,
   input  pb_pwr_op_e             req_op_i,
   input  logic [NumClusters-1:0] req_mask_i,
   output logic [NumClusters-1:0] clk_en_o,
   output logic [NumClusters-1:0] rst_no,
   output logic [NumClusters-1:0] isolate_o,
   input  logic [NumClusters-1:0] isolated_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic [NumClusters-1:0] err_mask_o,
   input  logic                   err_clear_i
);

   localparam int unsigned CntW = $clog2(pb_max3(ClkSettleCycles, RstHoldCycles, AckTimeout) + 1);
   localparam int unsigned IdxW = (NumClusters > 1) ? $clog2(NumClusters) : 1;

   // CLK_ON/RST_REL/UNISO bring a cluster up, ISO/RST_ASRT/CLK_OFF take it down.
   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_SELECT   = 4'd1,
      ST_CLK_ON   = 4'd2,
      ST_RST_REL  = 4'd3,
      ST_UNISO    = 4'd4,
      ST_ISO      = 4'd5,
      ST_RST_ASRT = 4'd6,
      ST_CLK_OFF  = 4'd7,
      ST_DONE     = 4'd8
   } state_e;

   state_e                 state_q, state_d;
   pb_pwr_op_e             op_q, op_d;
   logic [NumClusters-1:0] pend_q, pend_d;
   logic [IdxW-1:0]        idx_q, idx_d;
   logic [CntW-1:0]        cnt_q, cnt_d;
   logic [NumClusters-1:0] clk_en_q, clk_en_d;
   logic [NumClusters-1:0] rst_n_q, rst_n_d;
   logic [NumClusters-1:0] iso_q, iso_d;
   logic [NumClusters-1:0] err_mask_q, err_mask_d;
   logic                   err_q, err_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   ready_q, ready_d;

   logic [NumClusters-1:0] met_up_s, met_dn_s, met_s, work_s, err_set_s;
   logic [IdxW-1:0]        sel_idx_s;
   logic                   work_empty_s;
   logic                   ack_s;
   logic                   cnt_last_s;
   logic [CntW-1:0]        cnt_dec_s;

   // Clusters already in the requested end state are skipped without spending a cycle.
   assign met_up_s   = clk_en_q & rst_n_q & ~iso_q;
   assign met_dn_s   = ~clk_en_q & ~rst_n_q & iso_q;
   assign met_s      = (op_q == POWER_UP) ? met_up_s : met_dn_s;
   assign work_s     = pend_q & ~met_s;
   assign cnt_last_s = (cnt_q == CntW'(1));
   assign cnt_dec_s  = cnt_q - CntW'(1);

   // Only the active cluster's isolation status is looked at.
   assign ack_s = (op_q == POWER_UP) ? ~isolated_i[idx_q] : isolated_i[idx_q];

   pb_cluster_pwr_seq_lzc #(
      .Width (NumClusters)
   ) i_lzc (
      .in_i    (work_s),
      .cnt_o   (sel_idx_s),
      .empty_o (work_empty_s)
   );

   // Next-state and per-cluster output control of the sequencing FSM.
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      pend_d    = pend_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      clk_en_d  = clk_en_q;
      rst_n_d   = rst_n_q;
      iso_d     = iso_q;
      err_set_s = '0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i && ready_q) begin
               op_d    = req_op_i;
               pend_d  = req_mask_i;
               state_d = ST_SELECT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SELECT: begin
            if (work_empty_s) begin
               pend_d  = '0;
               state_d = ST_DONE;
            end else begin
               pend_d = work_s;
               idx_d  = sel_idx_s;
               if (op_q == POWER_UP) begin
                  clk_en_d[sel_idx_s] = 1'b1;
                  cnt_d               = CntW'(ClkSettleCycles);
                  state_d             = ST_CLK_ON;
               end else begin
                  iso_d[sel_idx_s] = 1'b1;
                  cnt_d            = CntW'(AckTimeout);
                  state_d          = ST_ISO;
               end
            end
         end
         ST_CLK_ON: begin
            if (cnt_last_s) begin
               rst_n_d[idx_q] = 1'b1;
               cnt_d          = CntW'(RstHoldCycles);
               state_d        = ST_RST_REL;
            end else begin
               cnt_d = cnt_dec_s;
            end
         end
         ST_RST_REL: begin
            if (cnt_last_s) begin
               iso_d[idx_q] = 1'b0;
               cnt_d        = CntW'(AckTimeout);
               state_d      = ST_UNISO;
            end else begin
               cnt_d = cnt_dec_s;
            end
         end
         ST_UNISO: begin
            if (ack_s) begin
               pend_d[idx_q] = 1'b0;
               state_d       = ST_SELECT;
            end else if (cnt_last_s) begin
               // Timed out: flag it, keep the port isolated, leave clock and reset on.
               err_set_s[idx_q] = 1'b1;
               iso_d[idx_q]     = 1'b1;
               pend_d[idx_q]    = 1'b0;
               state_d          = ST_SELECT;
            end else begin
               cnt_d = cnt_dec_s;
            end
         end
         ST_ISO: begin
            if (ack_s) begin
               state_d = ST_RST_ASRT;
            end else if (cnt_last_s) begin
               // Timed out: flag it and carry on shutting the cluster down.
               err_set_s[idx_q] = 1'b1;
               iso_d[idx_q]     = 1'b1;
               state_d          = ST_RST_ASRT;
            end else begin
               cnt_d = cnt_dec_s;
            end
         end
         ST_RST_ASRT: begin
            rst_n_d[idx_q] = 1'b0;
            cnt_d          = CntW'(ClkSettleCycles);
            state_d        = ST_CLK_OFF;
         end
         ST_CLK_OFF: begin
            if (cnt_last_s) begin
               clk_en_d[idx_q] = 1'b0;
               pend_d[idx_q]   = 1'b0;
               state_d         = ST_SELECT;
            end else begin
               cnt_d = cnt_dec_s;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Sticky error flags; a new timeout wins over a simultaneous clear.
   always_comb begin
      if (err_clear_i) begin
         err_mask_d = err_set_s;
      end else begin
         err_mask_d = err_mask_q | err_set_s;
      end
      err_d   = |err_mask_d;
      busy_d  = (state_d != ST_IDLE);
      ready_d = (state_d == ST_IDLE);
      done_d  = (state_d == ST_DONE);
   end

   // State and output registers; reset leaves every cluster off and isolated.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= ST_IDLE;
         op_q       <= POWER_UP;
         pend_q     <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         clk_en_q   <= '0;
         rst_n_q    <= '0;
         iso_q      <= '1;
         err_mask_q <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ready_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         pend_q     <= pend_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         clk_en_q   <= clk_en_d;
         rst_n_q    <= rst_n_d;
         iso_q      <= iso_d;
         err_mask_q <= err_mask_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         ready_q    <= ready_d;
      end
   end

   assign req_ready_o = ready_q;
   assign clk_en_o    = clk_en_q;
   assign rst_no      = rst_n_q;
   assign isolate_o   = iso_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign err_mask_o  = err_mask_q;

endmodule
